sincos_atan2: RTL

- Inverse of the quarter-wave sin/cos ROM: converts a signed vector (x,y) into a 10-bit heading angle (1024 steps per turn).
- Uses the same angle convention and ROM word format as the rest of the design.
- Sits beside the sincos ROM and drives its read port. Used for saucer aiming, i.e. the angle from the saucer to the ship.
- Multi-cycle: quadrant fold, then an 8-step binary search over ROM entries.

---
 rtl/sincos_atan2.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sincos_atan2.sv
// sincos_atan2: (x,y) to 10-bit heading via quadrant fold + ROM binary search.
// Define SINCOS_ATAN2_MAG_EN to add the mag output (one extra ROM lookup).
module sincos_atan2 #(
  parameter int W       = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                busy,
  output logic                done,
  output logic [9:0]          angle,
  output logic                zero_vec,
`ifdef SINCOS_ATAN2_MAG_EN
  output logic [W:0]          mag,
`endif
  output logic [7:0]          rom_address,
  input  logic [35:0]         rom_q
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLD,
    S_ISSUE,
    S_WAIT,
    S_CMP,
    S_FIN
  } state_t;

  state_t state, nstate;

  logic signed [W-1:0] xr, yr;
  logic [W-1:0]        xp, yp;
  logic [1:0]          quad;
  logic [7:0]          k;
  logic [2:0]          bidx;
  logic [3:0]          wcnt;
  logic [7:0]          trial;
  logic [7:0]          issue_addr;
  logic [17:0]         rsin, rcos;
  logic [W+17:0]       lhs, rhs;
  logic                take;
  logic                last_cmp;
  logic                search_cmp;
  logic                zero_in;

  logic signed [W:0]   xe, ye, xn, yn;
  logic [W-1:0]        fx, fy;
  logic [1:0]          fq;
  logic                xpos, xneg, ypos, yneg;

  assign rsin  = rom_q[35:18];
  assign rcos  = rom_q[17:0];
  assign trial = k | (8'd1 << bidx);
  assign lhs   = {18'd0, yp} * {{W{1'b0}}, rcos};
  assign rhs   = {18'd0, xp} * {{W{1'b0}}, rsin};
  assign take  = (lhs >= rhs);
  assign busy  = (state != S_IDLE);

  // W+1 bits so that negating the most negative input stays positive
  assign xe = {xr[W-1], xr};
  assign ye = {yr[W-1], yr};
  assign xn = -xe;
  assign yn = -ye;

  assign xpos    = ~xr[W-1] & (|xr);
  assign xneg    = xr[W-1];
  assign ypos    = ~yr[W-1] & (|yr);
  assign yneg    = yr[W-1];
  assign zero_in = ~(|xr) & ~(|yr);

`ifdef SINCOS_ATAN2_MAG_EN
  localparam int MW = W + 1;
  logic          mag_ph;
  logic [W+18:0] msum;
  logic [W:0]    magr;

  assign msum = {19'd0, xp} * {{(W+1){1'b0}}, rcos}
              + {19'd0, yp} * {{(W+1){1'b0}}, rsin};
  assign last_cmp   = mag_ph;
  assign search_cmp = ~mag_ph;
  assign issue_addr = mag_ph ? k : trial;
`else
  assign last_cmp   = (bidx == 3'd0);
  assign search_cmp = 1'b1;
  assign issue_addr = trial;
`endif

  // Rotate the vector into the first quadrant and note which one it was
  always_comb begin
    fq = 2'd0;
    fx = W'(xe);
    fy = W'(ye);
    unique case (1'b1)
      xpos & ~yneg: begin
        fq = 2'd0;
        fx = W'(xe);
        fy = W'(ye);
      end
      ~xpos & ypos: begin
        fq = 2'd1;
        fx = W'(ye);
        fy = W'(xn);
      end
      xneg & ~ypos: begin
        fq = 2'd2;
        fx = W'(xn);
        fy = W'(yn);
      end
      ~xneg & yneg: begin
        fq = 2'd3;
        fx = W'(yn);
        fy = W'(xe);
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:  if (start) nstate = S_FOLD;
      S_FOLD:  nstate = zero_in ? S_FIN : S_ISSUE;
      S_ISSUE: nstate = S_WAIT;
      S_WAIT:  if (wcnt == 4'(ROM_LAT - 1)) nstate = S_CMP;
      S_CMP:   nstate = last_cmp ? S_FIN : S_ISSUE;
      S_FIN:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Operand capture, search bookkeeping, ROM address and result outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xr          <= '0;
      yr          <= '0;
      xp          <= '0;
      yp          <= '0;
      quad        <= 2'd0;
      k           <= 8'd0;
      bidx        <= 3'd0;
      wcnt        <= 4'd0;
      rom_address <= 8'd0;
      done        <= 1'b0;
      angle       <= 10'd0;
      zero_vec    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            xr <= x_in;
            yr <= y_in;
          end
        end
        S_FOLD: begin
          xp   <= fx;
          yp   <= fy;
          quad <= fq;
          k    <= 8'd0;
          bidx <= 3'd7;
        end
        S_ISSUE: begin
          rom_address <= issue_addr;
          wcnt        <= 4'd0;
        end
        S_WAIT: wcnt <= wcnt + 4'd1;
        S_CMP: begin
          if (search_cmp) begin
            if (take) k <= trial;
            bidx <= bidx - 3'd1;
          end
        end
        S_FIN: begin
          done     <= 1'b1;
          zero_vec <= zero_in;
          angle    <= zero_in ? 10'd0 : {quad, k};
        end
        default: ;
      endcase
    end
  end

`ifdef SINCOS_ATAN2_MAG_EN
  // Magnitude lookup after the search, published together with the angle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mag_ph <= 1'b0;
      magr   <= '0;
      mag    <= '0;
    end else begin
      if (state == S_FOLD) mag_ph <= 1'b0;
      if (state == S_CMP) begin
        if (!mag_ph && bidx == 3'd0) mag_ph <= 1'b1;
        if (mag_ph) magr <= MW'(msum >> 17);
      end
      if (state == S_FIN) mag <= zero_in ? '0 : magr;
    end
  end
`endif

endmodule
